// File: rtl/sdio_dat_tx_pkg.sv
// ============================================================================
// Module : sdio_dat_tx_pkg
// Brief  : Shared state encoding and constants for the SDIO DAT transmitter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdio_dat_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CRC   = 3'd3,
        ST_END   = 3'd4
    } state_t;

    localparam int          C_CRC_LEN     = 16;
    localparam int          C_MAX_BLK_LEN = 512;
    localparam logic [15:0] C_CRC_POLY    = 16'h1021;

endpackage

`default_nettype wire

// File: rtl/sdio_dat_tx_crc16.sv
// ============================================================================
// Module : crc16
// Brief  : Serial CRC16-CCITT (x^16+x^12+x^5+1) generator, zero init, with
//          shift-out mode that drains the register MSB first.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc16
    import sdio_dat_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_gen_en,
    input  logic i_out_en,
    input  logic i_din,
    output logic o_dout
);

    logic [C_CRC_LEN-1:0] r_crc;
    logic                 w_fb;

    assign w_fb   = i_din ^ r_crc[C_CRC_LEN-1];
    assign o_dout = r_crc[C_CRC_LEN-1];

    // Shift-out fills with zeros, so a full drain leaves the register cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= '0;
        end else if (i_gen_en) begin
            r_crc <= {r_crc[C_CRC_LEN-2:0], 1'b0} ^ (w_fb ? C_CRC_POLY : 16'h0000);
        end else if (i_out_en) begin
            r_crc <= {r_crc[C_CRC_LEN-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdio_dat_tx.sv
// ============================================================================
// Module : sdio_dat_tx
// Brief  : 1-bit SDIO read-data block serialiser: start bit, payload MSB
//          first, CRC16, end bit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdio_dat_tx
    import sdio_dat_tx_pkg::*;
#(
    parameter int LEN_W       = 10,
    parameter int MAX_BLK_LEN = C_MAX_BLK_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_blk_len,
    input  logic             i_abort,
    input  logic [7:0]       i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic             o_dat_out,
    output logic             o_dat_oe,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_underrun
);

    localparam logic [LEN_W:0] C_ONE     = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] C_MAX_CNT = (LEN_W+1)'(MAX_BLK_LEN);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_bit_cnt;
    logic [LEN_W:0] r_byte_cnt;
    logic [3:0]     r_crc_cnt;
    logic [7:0]     r_shift;
    logic           r_dat_out;
    logic           r_dat_oe;
    logic           r_end_q;
    logic           r_done;
    logic           r_underrun;
    logic           r_crc_clr;

    logic           w_next_bit;
    logic           w_tx_ready;
    logic           w_gen_en;
    logic           w_out_en;
    logic           w_abort_act;
    logic           w_crc_rst;
    logic           w_crc_dout;
    logic [LEN_W:0] w_blk_cnt;

    assign w_blk_cnt   = (i_blk_len == '0) ? C_MAX_CNT : {1'b0, i_blk_len};
    assign w_abort_act = i_abort && (r_state != ST_IDLE);
    assign w_crc_rst   = rst | r_crc_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_next_bit  = 1'b1;
        w_tx_ready  = 1'b0;
        w_gen_en    = 1'b0;
        w_out_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_next_bit  = 1'b0;
                w_tx_ready  = 1'b1;
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_next_bit = r_shift[7];
                w_gen_en   = 1'b1;
                // Next byte is fetched on the last bit of every byte but the final one.
                w_tx_ready = (r_bit_cnt == 3'd7) && (r_byte_cnt != C_ONE);
                if ((r_bit_cnt == 3'd7) && (r_byte_cnt == C_ONE)) begin
                    w_state_nxt = ST_CRC;
                end
            end
            ST_CRC: begin
                w_next_bit = w_crc_dout;
                w_out_en   = 1'b1;
                if (r_crc_cnt == 4'd15) begin
                    w_state_nxt = ST_END;
                end
            end
            ST_END: begin
                w_next_bit  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_abort_act) begin
            w_state_nxt = ST_IDLE;
            w_tx_ready  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dat_out  <= 1'b1;
            r_dat_oe   <= 1'b0;
            r_end_q    <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_crc_clr  <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= '0;
            r_crc_cnt  <= 4'd0;
            r_shift    <= 8'h00;
        end else begin
            r_dat_out <= w_abort_act ? 1'b1 : w_next_bit;
            r_dat_oe  <= (r_state != ST_IDLE) && !w_abort_act;
            r_crc_clr <= w_abort_act;
            r_end_q   <= (r_state == ST_END) && !w_abort_act;
            r_done    <= r_end_q;

            r_bit_cnt <= (r_state == ST_DATA) ? r_bit_cnt + 3'd1 : 3'd0;
            r_crc_cnt <= (r_state == ST_CRC) ? r_crc_cnt + 4'd1 : 4'd0;

            if ((r_state == ST_IDLE) && i_start) begin
                r_byte_cnt <= w_blk_cnt;
                r_underrun <= 1'b0;
            end else begin
                if ((r_state == ST_DATA) && (r_bit_cnt == 3'd7)) begin
                    r_byte_cnt <= r_byte_cnt - C_ONE;
                end
                if (w_tx_ready && !i_tx_valid) begin
                    r_underrun <= 1'b1;
                end
            end

            // A starved fetch sends zeros rather than stretching the line.
            if (w_tx_ready) begin
                r_shift <= i_tx_valid ? i_tx_data : 8'h00;
            end else if (r_state == ST_DATA) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end
        end
    end

    crc16 u_crc16 (
        .clk      (clk),
        .rst      (w_crc_rst),
        .i_gen_en (w_gen_en),
        .i_out_en (w_out_en),
        .i_din    (w_next_bit),
        .o_dout   (w_crc_dout)
    );

    assign o_tx_ready = w_tx_ready;
    assign o_dat_out  = r_dat_out;
    assign o_dat_oe   = r_dat_oe;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = r_done;
    assign o_underrun = r_underrun;

endmodule

`default_nettype wire
